wb_master_bridge: RTL

- Wishbone classic-cycle initiator: turns valid/ready commands into single or incrementing-burst Wishbone read/write cycles toward the user-area slaves (UART at 0x3000_0000, RAM at 0x3800_0000).
- Returns one response per beat.
- Sits upstream of the user-project address decoder and lets a local engine (test sequencer, DMA-style loader) drive the same slaves the management SoC drives.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_timeout_cnt.sv | 39 +++
 rtl/wb_master_bridge.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone master bridge.
package wb_pkg;

    // Bridge controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } wb_state_t;

    // Base addresses of the user-area slaves reachable through the bridge
    localparam logic [31:0] UART_BASE = 32'h3000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h3800_0000;

    // One response beat as presented to the command source
    localparam int RSP_DAT_W = 32;
    typedef struct packed {
        logic [RSP_DAT_W-1:0] dat;
        logic                 err;
        logic                 last;
    } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Wait counter for a pending strobe; flags expiry once it reaches TIMEOUT.
// TIMEOUT = 0 disables expiry entirely.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // Next count: clear wins, then count up while enabled and not yet expired
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic-cycle initiator: turns valid/ready commands into single or
// incrementing-burst read/write cycles and returns one response per beat.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               rsp_last,
    output logic               busy,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    input  logic [DAT_W-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i
);

    localparam int BYTES = DAT_W / 8;

    wb_state_t          state_q, state_d;
    logic               we_q, we_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [BYTES-1:0]   sel_q, sel_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_last_q, rsp_last_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               expired;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .clear   (state_q != REQ),
        .enable  (state_q == REQ),
        .expired (expired)
    );

    // Next state, captured command/response data, and the registered outputs
    // derived from where the controller will be on the next cycle
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cnt_d   = cmd_len;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (wbm_err_i) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RSP;
                end else if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = RSP;
                end else if (expired) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        adr_d   = adr_q + ADR_W'(BYTES);
                        state_d = REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        stb_d       = (state_d == REQ);
        rsp_valid_d = (state_d == RSP);
        cyc_d       = (state_d == REQ) ||
                      ((state_d == RSP) && (cnt_d != '0) && !rsp_err_d);
        rsp_last_d  = (state_d == RSP) && ((cnt_d == '0) || rsp_err_d);
    end

    // State, datapath and output registers; reset drops the bus at once
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            rsp_valid_q <= rsp_valid_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
